// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the loader state encoding.
// The IMEM read side imports the same constants.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned ADDR_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } ld_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into one 32-bit word.
// A clear zeroes the word, so any bytes that were never filled read as 0x00.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [1:0]  byte_idx,
  output logic [31:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (accept) begin
      word[{byte_idx, 3'b000} +: 8] <= data;
      byte_idx                      <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams an image byte-by-byte into instruction memory, one word write per
// four bytes (or per short final word), with overflow detection at IMEM_DEPTH.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = imem_pkg::IMEM_DEPTH,
  parameter int unsigned ADDR_W     = imem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              IMEM_wr_en,
  output logic [ADDR_W-1:0] IMEM_wr_addr,
  output logic [31:0]       IMEM_wr_data,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [6:0]        ld_word_count
);

  import imem_pkg::*;

  ld_state_t  state;
  logic       word_last;
  logic       accept;
  logic       complete;
  logic       pack_clear;
  logic       last_slot;
  logic [1:0] byte_idx;

  always_comb begin
    accept     = ld_ready & ld_valid;
    complete   = accept & ((byte_idx == 2'd3) | ld_last);
    last_slot  = (ld_word_count == 7'(IMEM_DEPTH - 1));
    // The packer is emptied as the write retires, so WRITE sees a stable word.
    pack_clear = (state == WRITE) | (((state == IDLE) | (state == DONE)) & ld_start);
  end

  word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pack_clear),
    .accept   (accept),
    .data     (ld_byte),
    .byte_idx (byte_idx),
    .word     (IMEM_wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ld_ready      <= 1'b0;
      IMEM_wr_en    <= 1'b0;
      IMEM_wr_addr  <= '0;
      ld_busy       <= 1'b0;
      ld_done       <= 1'b0;
      ld_err        <= 1'b0;
      ld_word_count <= '0;
      word_last     <= 1'b0;
    end else begin
      IMEM_wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (ld_start) begin
            state         <= COLLECT;
            ld_ready      <= 1'b1;
            ld_busy       <= 1'b1;
            ld_done       <= 1'b0;
            ld_err        <= 1'b0;
            ld_word_count <= '0;
          end
        end
        COLLECT: begin
          if (complete) begin
            state        <= WRITE;
            ld_ready     <= 1'b0;
            IMEM_wr_en   <= 1'b1;
            IMEM_wr_addr <= ADDR_W'({ld_word_count, 2'b00});
            word_last    <= ld_last;
          end
        end
        WRITE: begin
          ld_word_count <= ld_word_count + 7'd1;
          if (word_last || last_slot) begin
            state   <= DONE;
            ld_busy <= 1'b0;
            ld_done <= 1'b1;
            ld_err  <= ~word_last;
          end else begin
            state    <= COLLECT;
            ld_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
